// File: rtl/mandel_core_pkg.sv
// mandel_core_pkg: shared state encoding and fixed-point constants for the Mandelbrot core.
package mandel_core_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ITER, DONE} state_t;
  localparam int FIX_W = 16;
  localparam int FRAC_BITS = 12;
  localparam int ACC_W = 20;
  localparam int SUM_W = 21;
  localparam int ESCAPE_MAG = 16384;
  localparam int X_RES = 320;
  localparam int Y_RES = 240;
endpackage

// File: rtl/mandel_step.sv
// mandel_step: one combinational z <- z^2 + c iteration with |z|^2 > 4 escape test.
module mandel_step
  import mandel_core_pkg::*;
#(
  parameter int FRAC = FRAC_BITS
) (
  input  logic signed [FIX_W-1:0] zr,
  input  logic signed [FIX_W-1:0] zi,
  input  logic signed [FIX_W-1:0] cr,
  input  logic signed [FIX_W-1:0] ci,
  output logic signed [FIX_W-1:0] zr_next,
  output logic signed [FIX_W-1:0] zi_next,
  output logic                    escape
);
  logic signed [2*FIX_W-1:0] p_rr, p_ii, p_ri;
  logic signed [ACC_W-1:0] zr2, zi2, zri2;
  logic signed [SUM_W-1:0] mag;
  always_comb begin
    p_rr = 32'(zr) * 32'(zr);
    p_ii = 32'(zi) * 32'(zi);
    p_ri = 32'(zr) * 32'(zi);
    zr2 = ACC_W'(p_rr >>> FRAC);
    zi2 = ACC_W'(p_ii >>> FRAC);
    // one less shift folds the factor of two in 2*zr*zi
    zri2 = ACC_W'(p_ri >>> (FRAC - 1));
    mag = SUM_W'(zr2) + SUM_W'(zi2);
    escape = mag > SUM_W'(ESCAPE_MAG);
    zr_next = FIX_W'(zr2 - zi2 + ACC_W'(cr));
    zi_next = FIX_W'(zri2 + ACC_W'(ci));
  end
endmodule

// File: rtl/mandel_core.sv
// mandel_core: iterates one pixel's Mandelbrot orbit and reports escape count and colour.
module mandel_core
  import mandel_core_pkg::*;
#(
  parameter int FRAC   = FRAC_BITS,
  parameter int CR_MIN = -8192,
  parameter int CI_MIN = -4560,
  parameter int STEP   = 38
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        calc,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [11:0] max_iter,
  output logic        busy,
  output logic        done,
  output logic [11:0] iter_count,
  output logic        in_set,
  output logic [2:0]  color
);
  state_t state, state_d;
  logic [9:0] x_q, y_q;
  logic [11:0] max_q, count;
  logic signed [FIX_W-1:0] cr, ci, zr, zi, zr_n, zi_n;
  logic escape, limit;

  mandel_step #(.FRAC(FRAC)) u_step (
    .zr(zr), .zi(zi), .cr(cr), .ci(ci),
    .zr_next(zr_n), .zi_next(zi_n), .escape(escape)
  );

  assign limit = count == max_q;
  assign busy  = state != IDLE;
  assign done  = state == DONE;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = calc ? SETUP : IDLE;
      SETUP:   state_d = ITER;
      ITER:    state_d = (limit || escape) ? DONE : ITER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      max_q <= '0;
      count <= '0;
      cr <= '0;
      ci <= '0;
      zr <= '0;
      zi <= '0;
      iter_count <= '0;
      in_set <= 1'b0;
      color <= '0;
    end else begin
      case (state)
        IDLE: if (calc) begin
          x_q <= x;
          y_q <= y;
          max_q <= max_iter;
        end
        SETUP: begin
          cr <= FIX_W'(CR_MIN + int'(x_q) * STEP);
          ci <= FIX_W'(CI_MIN + int'(y_q) * STEP);
          zr <= '0;
          zi <= '0;
          count <= '0;
        end
        ITER: begin
          // the iteration limit takes priority over escape
          if (limit) begin
            iter_count <= count;
            in_set <= 1'b1;
            color <= '0;
          end else if (escape) begin
            iter_count <= count;
            in_set <= 1'b0;
            color <= count[2:0];
          end else begin
            zr <= zr_n;
            zi <= zi_n;
            count <= count + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mandel_core.sv
// tb_mandel_core: directed and randomised scoreboard bench for mandel_core.
module tb_mandel_core;
  logic clock = 1'b0, reset = 1'b1, calc = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [11:0] max_iter = '0;
  logic busy, done, in_set;
  logic [11:0] iter_count;
  logic [2:0] color;
  int errors = 0, checks = 0;

  typedef struct {int n; bit s; int lat;} exp_t;
  exp_t q[$];

  mandel_core dut (
    .clock(clock), .reset(reset), .calc(calc), .x(x), .y(y), .max_iter(max_iter),
    .busy(busy), .done(done), .iter_count(iter_count), .in_set(in_set), .color(color)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int xi, input int yi, input int mi, output int n, output bit s);
    logic signed [15:0] cr, ci, zr, zi;
    logic signed [19:0] a, b, c;
    logic signed [20:0] m;
    int r, i;
    cr = 16'(-8192 + xi * 38);
    ci = 16'(-4560 + yi * 38);
    zr = '0;
    zi = '0;
    n = 0;
    s = 1'b1;
    while (n < mi) begin
      r = zr;
      i = zi;
      a = 20'((r * r) >>> 12);
      b = 20'((i * i) >>> 12);
      c = 20'((r * i) >>> 11);
      m = 21'(a) + 21'(b);
      if (m > 21'sd16384) begin
        s = 1'b0;
        break;
      end
      zr = 16'(int'(a) - int'(b) + int'(cr));
      zi = 16'(int'(c) + int'(ci));
      n++;
    end
  endfunction

  task automatic push(input int n, input bit s);
    exp_t e;
    e.n = n;
    e.s = s;
    e.lat = n + 3;
    q.push_back(e);
  endtask

  // caller sits at a negedge; leaves at the negedge after the sampling edge
  task automatic start(input int xi, input int yi, input int mi);
    x = 10'(xi);
    y = 10'(yi);
    max_iter = 12'(mi);
    calc = 1'b1;
    @(negedge clock);
    calc = 1'b0;
  endtask

  task automatic collect(input string tag, input int lat0);
    int lat;
    exp_t e;
    lat = lat0;
    while (!done && lat < 5000) begin
      @(negedge clock);
      lat++;
    end
    check({tag, " done_seen"}, int'(done), 1);
    if (q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 0, 1);
    end else begin
      e = q.pop_front();
      check({tag, " iter_count"}, int'(iter_count), e.n);
      check({tag, " in_set"}, int'(in_set), int'(e.s));
      check({tag, " color"}, int'(color), e.s ? 0 : (e.n & 7));
      check({tag, " latency"}, lat, e.lat);
    end
  endtask

  initial begin
    int n, dcount, xi, yi, mi;
    bit s;
    @(negedge clock);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset iter_count", int'(iter_count), 0);
    check("reset in_set", int'(in_set), 0);
    check("reset color", int'(color), 0);
    reset = 1'b0;
    @(negedge clock);

    push(1, 0);
    start(0, 0, 100);
    check("busy_after_calc", int'(busy), 1);
    collect("origin", 1);
    @(negedge clock);
    check("idle_after_done", int'(busy), 0);

    push(100, 1);
    start(216, 120, 100);
    collect("in_set_point", 1);
    @(negedge clock);

    push(0, 1);
    start(123, 77, 0);
    collect("max_iter_zero", 1);
    @(negedge clock);

    push(2, 0);
    start(319, 0, 50);
    x = 10'd0;
    calc = 1'b1;
    @(negedge clock);
    calc = 1'b0;
    collect("busy_calc_ignored", 2);
    @(negedge clock);
    dcount = 0;
    repeat (10) begin
      if (busy || done) dcount++;
      @(negedge clock);
    end
    check("no_run_from_ignored_calc", dcount, 0);

    start(216, 120, 100);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort iter_count", int'(iter_count), 0);
    check("abort in_set", int'(in_set), 0);
    check("abort color", int'(color), 0);
    @(negedge clock);
    reset = 1'b0;
    dcount = 0;
    repeat (120) begin
      @(negedge clock);
      if (done || busy) dcount++;
    end
    check("no_done_after_abort", dcount, 0);
    push(1, 0);
    start(0, 0, 100);
    collect("after_reset", 1);

    calc = 1'b1;
    @(negedge clock);
    calc = 1'b0;
    check("calc_in_done_ignored busy", int'(busy), 0);
    @(negedge clock);
    check("calc_in_done_ignored idle", int'(busy), 0);

    push(2, 0);
    start(319, 0, 50);
    collect("b2b_first", 1);
    @(negedge clock);
    push(1, 0);
    start(0, 0, 100);
    collect("b2b_second", 1);
    @(negedge clock);

    for (int k = 0; k < 8; k++) begin
      xi = int'($urandom_range(319, 0));
      yi = int'($urandom_range(239, 0));
      mi = int'($urandom_range(60, 0));
      model(xi, yi, mi, n, s);
      push(n, s);
      start(xi, yi, mi);
      collect("random", 1);
      @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
